bus_slot_arbiter: RTL and testbench

//  Time-slot arbiter for the shared SRAM/IO bus, driven by clk16. Splits each 16-clock frame
//  (one 1 MHz CPU cycle) into a Pi slot (counts 0-7) and a CPU slot (counts 8-15).

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_timing_counter.sv | 23 ++
 rtl/bus_slot_arbiter.sv | 92 +++++++++
 tb/tb_bus_slot_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - slot boundaries, Pi FSM encoding and window helper for the bus slot arbiter
package bus_pkg;

    localparam int COUNT_W = 4;

    localparam logic [COUNT_W-1:0] COUNT_ONE      = 4'd1;
    localparam logic [COUNT_W-1:0] PI_SLOT_FIRST  = 4'd0;
    localparam logic [COUNT_W-1:0] PI_SLOT_LAST   = 4'd7;
    localparam logic [COUNT_W-1:0] CPU_SLOT_FIRST = 4'd8;
    localparam logic [COUNT_W-1:0] CPU_SLOT_LAST  = 4'd15;
    localparam logic [COUNT_W-1:0] CPU_CLK_FIRST  = 4'd12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic in_window(input logic [COUNT_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

// File: rtl/bus_timing_counter.sv
// rtl/bus_timing_counter.sv - free-running 16-clock frame counter with slot-start flags
module bus_timing_counter
    import bus_pkg::*;
(
    input  logic               clk16,
    input  logic               reset,
    output logic [COUNT_W-1:0] count,
    output logic               pi_slot_start,
    output logic               cpu_slot_start
);

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + COUNT_ONE;
        end
    end

    assign pi_slot_start  = (count == PI_SLOT_FIRST);
    assign cpu_slot_start = (count == CPU_SLOT_FIRST);

endmodule

// File: rtl/bus_slot_arbiter.sv
// rtl/bus_slot_arbiter.sv - splits each 16-clock frame into a Pi slot and a CPU slot
// Outputs are registered from the upcoming count so each is high in the cycle its count is current.
module bus_slot_arbiter
    import bus_pkg::*;
#(
    parameter int PI_STROBE_START  = 3,
    parameter int PI_STROBE_END    = 5,
    parameter int CPU_STROBE_START = 12,
    parameter int CPU_STROBE_END   = 14
) (
    input  logic clk16,
    input  logic reset,
    input  logic pi_req,
    input  logic cpu_en,
    input  logic cpu_io_addr,
    output logic pi_select,
    output logic pi_strobe,
    output logic pi_done,
    output logic cpu_select,
    output logic io_select,
    output logic cpu_strobe,
    output logic cpu_clk
);

    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               pi_slot_start;
    logic               cpu_slot_start;
    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               cpu_active;
    logic               cpu_active_next;
    logic               io_latch;
    logic               io_latch_next;
    logic               cpu_sel_next;

    bus_timing_counter u_counter (
        .clk16          (clk16),
        .reset          (reset),
        .count          (count),
        .pi_slot_start  (pi_slot_start),
        .cpu_slot_start (cpu_slot_start)
    );

    // GRANT covers counts 1-6; DONE holds through counts 7-8 so pi_done fires once on entry.
    always_comb begin
        count_next = count + COUNT_ONE;
        state_next = state;
        case (state)
            ST_IDLE:  if (pi_slot_start && pi_req) state_next = ST_GRANT;
            ST_GRANT: if (count_next == PI_SLOT_LAST) state_next = ST_DONE;
            ST_DONE:  if (cpu_slot_start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_active_next = (count_next == CPU_SLOT_FIRST) ? cpu_en      : cpu_active;
        io_latch_next   = (count_next == CPU_SLOT_FIRST) ? cpu_io_addr : io_latch;
        cpu_sel_next    = cpu_active_next &&
                          in_window(count_next, int'(CPU_SLOT_FIRST), int'(CPU_SLOT_LAST));
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cpu_active <= 1'b0;
            io_latch   <= 1'b0;
            pi_select  <= 1'b0;
            pi_strobe  <= 1'b0;
            pi_done    <= 1'b0;
            cpu_select <= 1'b0;
            io_select  <= 1'b0;
            cpu_strobe <= 1'b0;
            cpu_clk    <= 1'b0;
        end else begin
            state      <= state_next;
            cpu_active <= cpu_active_next;
            io_latch   <= io_latch_next;
            pi_select  <= (state_next == ST_GRANT);
            pi_strobe  <= (state_next == ST_GRANT) &&
                          in_window(count_next, PI_STROBE_START, PI_STROBE_END);
            pi_done    <= (state == ST_GRANT) && (state_next == ST_DONE);
            cpu_select <= cpu_sel_next;
            io_select  <= cpu_sel_next && io_latch_next;
            cpu_strobe <= cpu_sel_next && in_window(count_next, CPU_STROBE_START, CPU_STROBE_END);
            cpu_clk    <= cpu_sel_next &&
                          in_window(count_next, int'(CPU_CLK_FIRST), int'(CPU_SLOT_LAST));
        end
    end

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// tb/tb_bus_slot_arbiter.sv - scoreboard bench for bus_slot_arbiter
module tb_bus_slot_arbiter;

    logic clk16       = 1'b0;
    logic reset       = 1'b0;
    logic pi_req      = 1'b0;
    logic cpu_en      = 1'b0;
    logic cpu_io_addr = 1'b0;
    logic pi_select, pi_strobe, pi_done, cpu_select, io_select, cpu_strobe, cpu_clk;

    typedef struct packed {
        logic ps;
        logic pst;
        logic pd;
        logic cs;
        logic is;
        logic cst;
        logic ck;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_cnt  = 0;
    bit   m_grant = 1'b0;
    bit   m_cpu   = 1'b0;
    bit   m_io    = 1'b0;
    int   cyc       = 0;
    int   last_done = -1;
    int   done_seen = 0;
    bit   gap_check = 1'b0;

    bus_slot_arbiter dut (
        .clk16       (clk16),
        .reset       (reset),
        .pi_req      (pi_req),
        .cpu_en      (cpu_en),
        .cpu_io_addr (cpu_io_addr),
        .pi_select   (pi_select),
        .pi_strobe   (pi_strobe),
        .pi_done     (pi_done),
        .cpu_select  (cpu_select),
        .io_select   (io_select),
        .cpu_strobe  (cpu_strobe),
        .cpu_clk     (cpu_clk)
    );

    always #5 clk16 = ~clk16;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_grant = 1'b0;
        m_cpu   = 1'b0;
        m_io    = 1'b0;
    endtask

    // Frame-level expectation: decide grant at count 0 and CPU enable at count 8, then window by count.
    task automatic model_step(output exp_t e);
        int c;
        c = (m_cnt + 1) % 16;
        if (m_cnt == 0) m_grant = pi_req;
        if (c == 8) begin
            m_cpu = cpu_en;
            m_io  = cpu_io_addr;
        end
        e.ps  = m_grant && (c >= 1) && (c <= 6);
        e.pst = m_grant && (c >= 3) && (c <= 5);
        e.pd  = m_grant && (c == 7);
        e.cs  = m_cpu && (c >= 8);
        e.is  = m_cpu && m_io && (c >= 8);
        e.cst = m_cpu && (c >= 12) && (c <= 14);
        e.ck  = m_cpu && (c >= 12);
        m_cnt = c;
    endtask

    task automatic compare_outputs(input string pfx);
        exp_t e;
        e = sb.pop_front();
        check({pfx, "pi_select"},  pi_select,  e.ps);
        check({pfx, "pi_strobe"},  pi_strobe,  e.pst);
        check({pfx, "pi_done"},    pi_done,    e.pd);
        check({pfx, "cpu_select"}, cpu_select, e.cs);
        check({pfx, "io_select"},  io_select,  e.is);
        check({pfx, "cpu_strobe"}, cpu_strobe, e.cst);
        check({pfx, "cpu_clk"},    cpu_clk,    e.ck);
    endtask

    task automatic cycle();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk16);
        #1;
        cyc++;
        compare_outputs("");
        if (gap_check && pi_done === 1'b1) begin
            if (last_done >= 0) check_int("done_gap", cyc - last_done, 16);
            last_done = cyc;
            done_seen++;
        end
    endtask

    task automatic reset_cycle();
        sb.push_back('0);
        @(posedge clk16);
        #1;
        cyc++;
        compare_outputs("rst_");
    endtask

    task automatic run_to(input int n);
        cycle();
        while (m_cnt != n) cycle();
    endtask

    always @(negedge clk16) begin
        check("inv_select_excl",   pi_select && cpu_select, 1'b0);
        check("inv_pi_strobe",     pi_strobe && !pi_select, 1'b0);
        check("inv_cpu_strobe",    cpu_strobe && !cpu_select, 1'b0);
        check("inv_io_in_cpu",     io_select && !cpu_select, 1'b0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held 5 clocks
        #2;
        reset = 1'b1;
        model_reset();
        repeat (5) reset_cycle();
        reset = 1'b0;

        // request present at count 0
        pi_req = 1'b1;
        run_to(7);
        pi_req = 1'b0;
        run_to(0);

        // request rising mid-frame waits for next frame
        run_to(2);
        pi_req = 1'b1;
        repeat (21) cycle();
        check("late_req_done_at_21", pi_done, 1'b1);
        pi_req = 1'b0;
        run_to(0);

        // CPU slot: io then memory, then halted
        run_to(6);
        cpu_en      = 1'b1;
        cpu_io_addr = 1'b1;
        run_to(10);
        cpu_io_addr = 1'b0;
        run_to(10);
        cpu_en = 1'b0;
        run_to(0);
        run_to(0);
        cpu_en      = 1'b1;
        cpu_io_addr = 1'b1;

        // back-to-back grants, drop during third
        run_to(12);
        pi_req    = 1'b1;
        gap_check = 1'b1;
        last_done = -1;
        done_seen = 0;
        run_to(0);
        run_to(0);
        run_to(0);
        run_to(4);
        pi_req = 1'b0;
        run_to(0);
        run_to(0);
        gap_check = 1'b0;
        check_int("b2b_done_count", done_seen, 3);

        // async reset mid-grant
        pi_req = 1'b1;
        run_to(4);
        check("pre_abort_pi_select", pi_select, 1'b1);
        reset = 1'b1;
        #1;
        sb.push_back('0);
        compare_outputs("async_");
        model_reset();
        pi_req = 1'b0;
        repeat (2) reset_cycle();
        reset = 1'b0;
        repeat (16) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
